gmii_to_atl32_packer: RTL and testbench



---
 rtl/gmii_to_atl32_packer.sv | 194 +++++++++++++++++++
 tb/tb_gmii_to_atl32_packer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_to_atl32_packer.sv
// GMII receive byte stream to 32-bit Atlantic word packer with optional
// preamble/SFD stripping and one-word lookahead so eop lands on the true last word.
module gmii_to_atl32_packer #(
  parameter logic BIG_ENDIAN     = 1'b1,
  parameter logic PREAMBLE_STRIP = 1'b1,
  parameter int   MAX_PRMBL      = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_en,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [31:0] dout,
  output logic        dval,
  output logic        derror,
  output logic        sop,
  output logic        eop,
  output logic [1:0]  tmod,
  output logic [15:0] drop_cnt
);

  localparam logic [7:0] SFD         = 8'hD5;
  localparam logic [8:0] PRMBL_LIMIT = 9'(MAX_PRMBL + 1);

  typedef enum logic [2:0] {IDLE, PRMBL, DATA, DROP, FLUSH} state_t;

  state_t      state_q, state_d;
  logic        armed_q;
  logic [8:0]  prm_cnt_q, prm_cnt_d;
  logic [31:0] acc_p0;
  logic [1:0]  lane_p0;
  logic [31:0] pend_p1;
  logic        vld_p1;
  logic        first_q;
  logic        err_q;
  logic        start, take, close, drop_inc;

  function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    int          sh;
    r  = w;
    sh = BIG_ENDIAN ? 8 * (3 - int'(lane)) : 8 * int'(lane);
    r[sh +: 8] = b;
    return r;
  endfunction

  // n = valid bytes in a partial word (1..3); a full word always encodes as 00
  function automatic logic [1:0] tmod_enc(input logic [1:0] n);
    return BIG_ENDIAN ? (2'd0 - n) : n;
  endfunction

  always_comb begin
    state_d   = state_q;
    prm_cnt_d = prm_cnt_q;
    start     = 1'b0;
    take      = 1'b0;
    close     = 1'b0;
    drop_inc  = 1'b0;
    if (rx_en) begin
      case (state_q)
        IDLE, FLUSH: begin
          state_d = IDLE;
          // armed_q demands a fresh rx_dv rising edge after reset
          if (rx_dv && armed_q) begin
            start = 1'b1;
            if (!PREAMBLE_STRIP) begin
              state_d = DATA;
              take    = 1'b1;
            end else if (rxd == SFD) begin
              state_d = DATA;
            end else begin
              state_d   = PRMBL;
              prm_cnt_d = 9'd1;
            end
          end
        end
        PRMBL: begin
          if (!rx_dv) begin
            state_d = IDLE;
          end else if (rxd == SFD) begin
            state_d = DATA;
          end else begin
            prm_cnt_d = prm_cnt_q + 9'd1;
            if (prm_cnt_d == PRMBL_LIMIT) state_d = DROP;
          end
        end
        DATA: begin
          if (!rx_dv) begin
            state_d = FLUSH;
            close   = 1'b1;
          end else begin
            take = 1'b1;
          end
        end
        DROP: begin
          if (!rx_dv) begin
            state_d  = IDLE;
            drop_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      prm_cnt_q <= '0;
      acc_p0    <= '0;
      lane_p0   <= '0;
      pend_p1   <= '0;
      vld_p1    <= 1'b0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      dout      <= '0;
      dval      <= 1'b0;
      derror    <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      tmod      <= '0;
      drop_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      prm_cnt_q <= prm_cnt_d;
      dval      <= 1'b0;
      derror    <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      tmod      <= '0;
      if (rx_en) begin
        if (!rx_dv) armed_q <= 1'b1;

        if (start) begin
          err_q   <= rx_er;
          first_q <= 1'b1;
        end else if (state_d == IDLE || state_d == FLUSH) begin
          err_q <= 1'b0;
        end else if (rx_dv) begin
          err_q <= err_q | rx_er;
        end

        // ---- stage p0 -> p1: byte lanes fill acc_p0, full word parks in pend_p1
        if (take) begin
          if (vld_p1) begin
            dout    <= pend_p1;
            dval    <= 1'b1;
            sop     <= first_q;
            first_q <= 1'b0;
          end
          if (lane_p0 == 2'd3) begin
            pend_p1 <= lane_put(acc_p0, lane_p0, rxd);
            vld_p1  <= 1'b1;
            acc_p0  <= '0;
            lane_p0 <= '0;
          end else begin
            vld_p1  <= 1'b0;
            acc_p0  <= lane_put(acc_p0, lane_p0, rxd);
            lane_p0 <= lane_p0 + 2'd1;
          end
        end

        // ---- stage p1 -> out: end of frame flushes the pending or partial word
        if (close) begin
          if (vld_p1) begin
            dout   <= pend_p1;
            dval   <= 1'b1;
            sop    <= first_q;
            eop    <= 1'b1;
            tmod   <= 2'b00;
            derror <= err_q;
          end else if (lane_p0 != 2'd0) begin
            dout   <= acc_p0;
            dval   <= 1'b1;
            sop    <= first_q;
            eop    <= 1'b1;
            tmod   <= tmod_enc(lane_p0);
            derror <= err_q;
          end
          acc_p0  <= '0;
          lane_p0 <= '0;
          vld_p1  <= 1'b0;
          first_q <= 1'b0;
        end

        if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_to_atl32_packer.sv
// Scoreboard bench: one big-endian and one little-endian packer share the same
// GMII stimulus; expected words are queued per instance and matched against observed words.
module tb_gmii_to_atl32_packer;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [1:0]  t;
    logic        er;
  } word_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_en = 1'b1;
  logic [7:0]  rxd = 8'h00;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [31:0] dout_v [2];
  logic        dval_v [2];
  logic        derror_v [2];
  logic        sop_v [2];
  logic        eop_v [2];
  logic [1:0]  tmod_v [2];
  logic [15:0] drop_v [2];

  word_t exp_q [2][$];
  word_t obs_q [2][$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    dval_off_en = 0;
  logic  last_en = 1'b0;

  always #5 clk = ~clk;

  gmii_to_atl32_packer #(.BIG_ENDIAN(1'b1), .PREAMBLE_STRIP(1'b1), .MAX_PRMBL(15)) u_be (
    .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .dout(dout_v[0]), .dval(dval_v[0]), .derror(derror_v[0]), .sop(sop_v[0]), .eop(eop_v[0]),
    .tmod(tmod_v[0]), .drop_cnt(drop_v[0]));

  gmii_to_atl32_packer #(.BIG_ENDIAN(1'b0), .PREAMBLE_STRIP(1'b1), .MAX_PRMBL(15)) u_le (
    .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .dout(dout_v[1]), .dval(dval_v[1]), .derror(derror_v[1]), .sop(sop_v[1]), .eop(eop_v[1]),
    .tmod(tmod_v[1]), .drop_cnt(drop_v[1]));

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (dval_v[k] === 1'b1)
        obs_q[k].push_back(word_t'({dout_v[k], sop_v[k], eop_v[k], tmod_v[k], derror_v[k]}));
    if ((dval_v[0] === 1'b1 || dval_v[1] === 1'b1) && !last_en) dval_off_en <= dval_off_en + 1;
    last_en <= rx_en;
  end

  task automatic drive(input logic en, input logic dv, input logic [7:0] b, input logic er);
    rx_en = en; rx_dv = dv; rxd = b; rx_er = er;
    @(posedge clk); #1;
  endtask

  task automatic put(input logic dv, input logic [7:0] b, input logic er, input bit tog);
    drive(1'b1, dv, b, er);
    if (tog) drive(1'b0, dv, 8'h5A, 1'b1);
  endtask

  task automatic send_frame(input int npre, input bit sfd, input int n, input logic [7:0] first,
                            input bit tog, input int er_idx, input int ngap);
    for (int i = 0; i < npre; i++) put(1'b1, 8'h55, 1'b0, tog);
    if (sfd) put(1'b1, 8'hD5, 1'b0, tog);
    for (int i = 0; i < n; i++) put(1'b1, 8'(first + i), (i == er_idx), tog);
    for (int i = 0; i < ngap; i++) put(1'b0, 8'h00, 1'b0, tog);
  endtask

  // Reference packing: k=0 big-endian lanes, k=1 little-endian lanes
  task automatic model_frame(input int n, input logic [7:0] first, input int er_idx);
    int    nw, nb;
    word_t w;
    logic [31:0] d;
    nw = (n + 3) / 4;
    for (int k = 0; k < 2; k++) begin
      for (int wi = 0; wi < nw; wi++) begin
        nb = (n - 4 * wi > 4) ? 4 : n - 4 * wi;
        d = '0;
        for (int j = 0; j < nb; j++) begin
          if (k == 0) d[31 - 8 * j -: 8] = 8'(first + 4 * wi + j);
          else        d[8 * j + 7 -: 8]  = 8'(first + 4 * wi + j);
        end
        w = '0;
        w.d = d;
        w.s = (wi == 0);
        w.e = (wi == nw - 1);
        if (w.e) begin
          if (k == 0) w.t = (nb == 4) ? 2'b00 : (nb == 3) ? 2'b01 : (nb == 2) ? 2'b10 : 2'b11;
          else        w.t = 2'(nb % 4);
          w.er = (er_idx >= 0 && er_idx < n);
        end
        exp_q[k].push_back(w);
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({dout_v[k], dval_v[k], derror_v[k], sop_v[k], eop_v[k], tmod_v[k], drop_v[k]} !== '0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: dout=%h dval=%b derr=%b sop=%b eop=%b tmod=%b drop=%0d, want all 0",
                 k, dout_v[k], dval_v[k], derror_v[k], sop_v[k], eop_v[k], tmod_v[k], drop_v[k]);
      end
    end
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_continuous;
    word_t e, o;
    exp_q[0].push_back(word_t'({32'h01020304, 1'b1, 1'b0, 2'b00, 1'b0}));
    exp_q[0].push_back(word_t'({32'h05060700, 1'b0, 1'b1, 2'b01, 1'b0}));
    exp_q[1].push_back(word_t'({32'h04030201, 1'b1, 1'b0, 2'b00, 1'b0}));
    exp_q[1].push_back(word_t'({32'h00070605, 1'b0, 1'b1, 2'b11, 1'b0}));
    send_frame(7, 1'b1, 7, 8'h01, 1'b0, -1, 3);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        n_bad++;
        $display("FAIL cont_count[%0d]: got %0d words, want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front(); o = obs_q[k].pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL cont_word[%0d]: got {dout,sop,eop,tmod,derr}=%h want %h", k, o, e);
        end
      end
      exp_q[k].delete(); obs_q[k].delete();
    end
  endtask

  task automatic test_single_byte;
    word_t e, o;
    exp_q[0].push_back(word_t'({32'hAA000000, 1'b1, 1'b1, 2'b11, 1'b0}));
    exp_q[1].push_back(word_t'({32'h000000AA, 1'b1, 1'b1, 2'b01, 1'b0}));
    send_frame(7, 1'b1, 1, 8'hAA, 1'b0, -1, 3);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        n_bad++;
        $display("FAIL single_count[%0d]: got %0d words, want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front(); o = obs_q[k].pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL single_word[%0d]: got {dout,sop,eop,tmod,derr}=%h want %h", k, o, e);
        end
      end
      exp_q[k].delete(); obs_q[k].delete();
    end
  endtask

  task automatic test_rx_en_toggle;
    word_t e, o;
    model_frame(8, 8'h01, 3);
    send_frame(7, 1'b1, 8, 8'h01, 1'b1, 3, 2);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        n_bad++;
        $display("FAIL toggle_count[%0d]: got %0d words, want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front(); o = obs_q[k].pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL toggle_word[%0d]: got {dout,sop,eop,tmod,derr}=%h want %h", k, o, e);
        end
      end
      exp_q[k].delete(); obs_q[k].delete();
    end
    n_cmp++;
    if (dval_off_en !== 0) begin
      n_bad++;
      $display("FAIL toggle_dval_idle: got %0d dval pulses after rx_en=0 cycles, want 0", dval_off_en);
    end
  endtask

  task automatic test_missing_sfd;
    word_t e, o;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (drop_v[k] !== 16'd0) begin
        n_bad++;
        $display("FAIL drop_before[%0d]: got %0d, want 0", k, drop_v[k]);
      end
    end
    send_frame(16, 1'b0, 0, 8'h00, 1'b0, -1, 3);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (drop_v[k] !== 16'd1) begin
        n_bad++;
        $display("FAIL drop_after[%0d]: got %0d, want 1", k, drop_v[k]);
      end
    end
    model_frame(6, 8'h10, -1);
    send_frame(7, 1'b1, 6, 8'h10, 1'b0, -1, 3);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        n_bad++;
        $display("FAIL drop_count_words[%0d]: got %0d words, want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front(); o = obs_q[k].pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL drop_next_word[%0d]: got {dout,sop,eop,tmod,derr}=%h want %h", k, o, e);
        end
      end
      exp_q[k].delete(); obs_q[k].delete();
    end
  endtask

  task automatic test_reset_mid_frame;
    word_t e, o;
    // the first full word leaves before reset; nothing else of that frame may follow
    exp_q[0].push_back(word_t'({32'h01020304, 1'b1, 1'b0, 2'b00, 1'b0}));
    exp_q[1].push_back(word_t'({32'h04030201, 1'b1, 1'b0, 2'b00, 1'b0}));
    send_frame(7, 1'b1, 5, 8'h01, 1'b0, -1, 0);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({dout_v[k], dval_v[k], derror_v[k], sop_v[k], eop_v[k], tmod_v[k], drop_v[k]} !== '0) begin
        n_bad++;
        $display("FAIL async_reset[%0d]: dout=%h dval=%b derr=%b sop=%b eop=%b tmod=%b drop=%0d, want all 0",
                 k, dout_v[k], dval_v[k], derror_v[k], sop_v[k], eop_v[k], tmod_v[k], drop_v[k]);
      end
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) put(1'b1, 8'(8'h06 + i), 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b0, 1'b0);
    model_frame(6, 8'h30, -1);
    send_frame(3, 1'b1, 6, 8'h30, 1'b0, -1, 3);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        n_bad++;
        $display("FAIL rstmid_count[%0d]: got %0d words, want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front(); o = obs_q[k].pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL rstmid_word[%0d]: got {dout,sop,eop,tmod,derr}=%h want %h", k, o, e);
        end
      end
      exp_q[k].delete(); obs_q[k].delete();
    end
  endtask

  task automatic test_back_to_back;
    word_t e, o;
    // one rx_dv=0 sample between frames; second frame uses the full 15-byte preamble allowance
    model_frame(5, 8'h40, 4);
    model_frame(4, 8'hC0, -1);
    send_frame(2, 1'b1, 5, 8'h40, 1'b0, 4, 1);
    send_frame(15, 1'b1, 4, 8'hC0, 1'b0, -1, 3);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs_q[k].size() != exp_q[k].size()) begin
        n_bad++;
        $display("FAIL b2b_count[%0d]: got %0d words, want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front(); o = obs_q[k].pop_front(); n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL b2b_word[%0d]: got {dout,sop,eop,tmod,derr}=%h want %h", k, o, e);
        end
      end
      exp_q[k].delete(); obs_q[k].delete();
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (drop_v[k] !== 16'd0) begin
        n_bad++;
        $display("FAIL b2b_drop[%0d]: got %0d, want 0", k, drop_v[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_single_byte;
    test_rx_en_toggle;
    test_missing_sfd;
    test_reset_mid_frame;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
